axis_write_mux: RTL and testbench

- N-channel AXI write-path multiplexer.
- Lets CHANNELS independent stream write engines (each an axis_write-style burst master) share one AXI AW/W/B port.
- AW is arbitrated per burst, round-robin. W beats follow AW grant order through an order FIFO. B responses are routed back by ID.
- Adds per-channel sticky write-error flags: bresp is checked, not ignored.

---
 rtl/axis_write_mux.sv | 175 +++++++++++++++++
 tb/tb_axis_write_mux.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_write_mux.sv
// N-channel AXI write multiplexer: round-robin AW arbitration per burst, W routed in
// grant order through an order FIFO, B routed back by ID with sticky per-channel error flags.
module axis_write_mux #(
    parameter int CHANNELS       = 4,
    parameter int CH_WIDTH       = 2,
    parameter int ORDER_AWIDTH   = 3,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNELS*AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [CHANNELS*AXI_LEN_WIDTH-1:0]    s_awlen,
    input  logic [CHANNELS-1:0]                  s_awvalid,
    output logic [CHANNELS-1:0]                  s_awready,
    input  logic [CHANNELS*AXI_DATA_WIDTH-1:0]   s_wdata,
    input  logic [CHANNELS-1:0]                  s_wlast,
    input  logic [CHANNELS-1:0]                  s_wvalid,
    output logic [CHANNELS-1:0]                  s_wready,
    output logic [CHANNELS-1:0]                  s_bvalid,
    input  logic [CHANNELS-1:0]                  s_bready,
    output logic [CHANNELS-1:0]                  wr_err,
    input  logic [CHANNELS-1:0]                  wr_err_clr,
    output logic [AXI_ADDR_WIDTH-1:0]            axi_awaddr,
    output logic [AXI_LEN_WIDTH-1:0]             axi_awlen,
    output logic [AXI_ID_WIDTH-1:0]              axi_awid,
    output logic                                 axi_awvalid,
    input  logic                                 axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]            axi_wdata,
    output logic [AXI_ID_WIDTH-1:0]              axi_wid,
    output logic                                 axi_wlast,
    output logic                                 axi_wvalid,
    input  logic                                 axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]              axi_bid,
    input  logic [1:0]                           axi_bresp,
    input  logic                                 axi_bvalid,
    output logic                                 axi_bready
);

    localparam int DEPTH = 2**ORDER_AWIDTH;

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    out_state_t                 r_state, w_state_next;
    logic [CH_WIDTH-1:0]        r_rr_ptr;
    logic [CH_WIDTH-1:0]        w_win;
    logic                       w_any;
    logic                       w_load;
    logic [AXI_ADDR_WIDTH-1:0]  r_awaddr;
    logic [AXI_LEN_WIDTH-1:0]   r_awlen;
    logic [AXI_ID_WIDTH-1:0]    r_awid;

    logic [ORDER_AWIDTH:0]      r_wr_ptr, r_rd_ptr;
    logic [CH_WIDTH-1:0]        r_fifo [DEPTH];
    logic                       w_full, w_empty, w_pop;
    logic [CH_WIDTH-1:0]        w_head;

    logic [CH_WIDTH-1:0]        w_bch;
    logic                       w_bid_ok;
    logic                       w_berr;
    logic [CHANNELS-1:0]        w_err_set;
    logic [CHANNELS-1:0]        r_wr_err;

    function automatic logic [CH_WIDTH-1:0] f_wrap(input logic [CH_WIDTH-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= CHANNELS)
            sum = sum - CHANNELS;
        return CH_WIDTH'(sum);
    endfunction

    // Walk offsets from the far end so the closest requester to rr_ptr is written last.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = CHANNELS-1; i >= 0; i--) begin
            if (s_awvalid[f_wrap(r_rr_ptr, i)]) begin
                w_any = 1'b1;
                w_win = f_wrap(r_rr_ptr, i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        s_awready    = '0;
        if (!rst && (r_state == OUT_EMPTY || axi_awready) && !w_full && w_any) begin
            w_load          = 1'b1;
            s_awready[w_win] = 1'b1;
            w_state_next    = OUT_FULL;
        end else if (r_state == OUT_FULL && axi_awready) begin
            w_state_next    = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= OUT_EMPTY;
            r_rr_ptr <= '0;
            r_awaddr <= '0;
            r_awlen  <= '0;
            r_awid   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_rr_ptr <= (w_win == CH_WIDTH'(CHANNELS-1)) ? '0 : w_win + 1'b1;
                r_awaddr <= s_awaddr[w_win*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                r_awlen  <= s_awlen[w_win*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
                r_awid   <= AXI_ID_WIDTH'(w_win);
            end
        end
    end

    assign axi_awvalid = (r_state == OUT_FULL);
    assign axi_awaddr  = r_awaddr;
    assign axi_awlen   = r_awlen;
    assign axi_awid    = r_awid;

    // Full is judged on the pre-pop occupancy, so a pop never frees a slot in its own cycle.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ORDER_AWIDTH] != r_rd_ptr[ORDER_AWIDTH]) &&
                     (r_wr_ptr[ORDER_AWIDTH-1:0] == r_rd_ptr[ORDER_AWIDTH-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_load)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load)
            r_fifo[r_wr_ptr[ORDER_AWIDTH-1:0]] <= w_win;
    end

    assign w_head     = r_fifo[r_rd_ptr[ORDER_AWIDTH-1:0]];
    assign axi_wvalid = !w_empty && s_wvalid[w_head];
    assign axi_wdata  = s_wdata[w_head*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign axi_wlast  = s_wlast[w_head];
    assign axi_wid    = AXI_ID_WIDTH'(w_head);
    assign w_pop      = axi_wvalid && axi_wready && axi_wlast;

    // Unknown IDs are sunk so a stray response can never stall the B channel.
    assign w_bch      = axi_bid[CH_WIDTH-1:0];
    assign w_bid_ok   = (axi_bid < AXI_ID_WIDTH'(CHANNELS));
    assign axi_bready = !rst && (w_bid_ok ? s_bready[w_bch] : 1'b1);
    assign w_berr     = axi_bvalid && axi_bready && w_bid_ok && (axi_bresp != 2'b00);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign s_wready[gi]  = axi_wready && !w_empty && (w_head == CH_WIDTH'(gi));
            assign s_bvalid[gi]  = !rst && axi_bvalid && w_bid_ok && (w_bch == CH_WIDTH'(gi));
            assign w_err_set[gi] = w_berr && (w_bch == CH_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wr_err <= '0;
        else
            r_wr_err <= (r_wr_err & ~wr_err_clr) | w_err_set;
    end

    assign wr_err = r_wr_err;

endmodule

// File: tb/tb_axis_write_mux.sv
// Directed bench for axis_write_mux: grant order, W ordering, FIFO-full blocking,
// B routing / error flags and asynchronous reset.
module tb_axis_write_mux;

    localparam int C  = 4;
    localparam int AW = 32;
    localparam int LW = 8;
    localparam int DW = 256;
    localparam int IW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [C*AW-1:0]   s_awaddr;
    logic [C*LW-1:0]   s_awlen;
    logic [C-1:0]      s_awvalid, s_awready;
    logic [C*DW-1:0]   s_wdata;
    logic [C-1:0]      s_wlast, s_wvalid, s_wready;
    logic [C-1:0]      s_bvalid, s_bready, wr_err, wr_err_clr;
    logic [AW-1:0]     axi_awaddr;
    logic [LW-1:0]     axi_awlen;
    logic [IW-1:0]     axi_awid;
    logic              axi_awvalid, axi_awready;
    logic [DW-1:0]     axi_wdata;
    logic [IW-1:0]     axi_wid;
    logic              axi_wlast, axi_wvalid, axi_wready;
    logic [IW-1:0]     axi_bid;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid, axi_bready;

    int n_checks = 0;
    int n_errors = 0;

    axis_write_mux dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .wr_err(wr_err), .wr_err_clr(wr_err_clr),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awid(axi_awid),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wid(axi_wid), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s_awaddr = '0; s_awlen = '0; s_awvalid = 4'hF; s_wdata = '0; s_wlast = '0;
        s_wvalid = '0; s_bready = '0; wr_err_clr = '0; axi_awready = 1'b0;
        axi_wready = 1'b0; axi_bid = '0; axi_bresp = '0; axi_bvalid = 1'b0;
        #2;
        check("rst_awvalid", axi_awvalid, 1'b0);
        check("rst_wvalid", axi_wvalid, 1'b0);
        check("rst_bready", axi_bready, 1'b0);
        check("rst_s_awready", s_awready, 4'b0000);
        check("rst_s_wready", s_wready, 4'b0000);
        check("rst_s_bvalid", s_bvalid, 4'b0000);
        check("rst_wr_err", wr_err, 4'b0000);
        tick; tick;
        s_awvalid = '0;
        rst = 1'b0;

        // Single channel 2 burst of 4 beats
        s_awaddr[2*AW +: AW] = 32'h1000;
        s_awlen[2*LW +: LW]  = 8'd3;
        s_awvalid = 4'b0100;
        settle;
        check("A_s_awready", s_awready, 4'b0100);
        tick;
        s_awvalid = '0; axi_awready = 1'b1; axi_wready = 1'b1; s_wvalid = 4'b0101;
        s_wdata[0 +: DW] = 256'hDEAD;
        settle;
        check("A_awvalid", axi_awvalid, 1'b1);
        check("A_awaddr", axi_awaddr, 32'h1000);
        check("A_awlen", axi_awlen, 8'd3);
        check("A_awid", axi_awid, 8'd2);
        for (int b = 0; b < 4; b++) begin
            s_wdata[2*DW +: DW] = 256'(32'hA0 + b);
            s_wlast = (b == 3) ? 4'b0101 : 4'b0000;
            settle;
            check("A_wvalid", axi_wvalid, 1'b1);
            check("A_wid", axi_wid, 8'd2);
            check("A_wdata", axi_wdata, 256'(32'hA0 + b));
            check("A_wlast", axi_wlast, (b == 3) ? 1'b1 : 1'b0);
            check("A_s_wready", s_wready, 4'b0100);
            tick;
        end
        settle;
        check("A_wvalid_after", axi_wvalid, 1'b0);
        check("A_s_wready_after", s_wready, 4'b0000);
        check("A_awvalid_after", axi_awvalid, 1'b0);
        s_wvalid = '0; s_wlast = '0;

        // Reset during beat 2 of a channel-1 burst (rr_ptr is 3 here)
        s_awaddr[1*AW +: AW] = 32'h2000;
        s_awlen[1*LW +: LW]  = 8'd3;
        s_awvalid = 4'b0010;
        settle;
        check("R_s_awready", s_awready, 4'b0010);
        tick;
        s_awvalid = '0; axi_awready = 1'b0;
        s_wvalid = 4'b0010; s_wdata[1*DW +: DW] = 256'hB0;
        tick;
        s_wdata[1*DW +: DW] = 256'hB1;
        settle;
        check("R_wvalid_beat2", axi_wvalid, 1'b1);
        check("R_awvalid_held", axi_awvalid, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("R_wvalid_async", axi_wvalid, 1'b0);
        check("R_awvalid_async", axi_awvalid, 1'b0);
        check("R_s_wready_async", s_wready, 4'b0000);
        tick;
        s_wvalid = 4'hF; s_wlast = 4'hF;
        rst = 1'b0;
        settle;
        check("R_fifo_empty", axi_wvalid, 1'b0);
        check("R_s_wready_empty", s_wready, 4'b0000);
        s_wvalid = '0; s_wlast = '0;

        // All channels requesting: grant order 0,1,2,3,0
        for (int k = 0; k < C; k++) begin
            s_awaddr[k*AW +: AW] = 32'h100 * (k + 1);
            s_awlen[k*LW +: LW]  = 8'd0;
            s_wdata[k*DW +: DW]  = 256'(32'h50 + k);
        end
        axi_awready = 1'b1; axi_wready = 1'b0; s_awvalid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            settle;
            check("B_s_awready", s_awready, 256'(1 << (g % 4)));
            tick;
            check("B_awid", axi_awid, 256'(g % 4));
            check("B_awaddr", axi_awaddr, 256'(32'h100 * ((g % 4) + 1)));
        end
        s_awvalid = '0; s_wvalid = 4'hF; s_wlast = 4'hF; axi_wready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            settle;
            check("B_wid", axi_wid, 256'(g % 4));
            check("B_wdata", axi_wdata, 256'(32'h50 + (g % 4)));
            check("B_s_wready", s_wready, 256'(1 << (g % 4)));
            tick;
        end
        settle;
        check("B_wvalid_done", axi_wvalid, 1'b0);
        s_wvalid = '0; axi_wready = 1'b0;

        // Fill the order FIFO (rr_ptr is 1): 8 grants, the ninth must wait for a pop
        s_awvalid = 4'hF;
        for (int g = 0; g < 8; g++) begin
            settle;
            check("C_s_awready", s_awready, 256'(1 << ((g + 1) % 4)));
            tick;
        end
        settle;
        check("C_full_block", s_awready, 4'b0000);
        tick;
        settle;
        check("C_full_block2", s_awready, 4'b0000);
        axi_wready = 1'b1; s_wvalid = 4'hF; s_wlast = 4'hF;
        settle;
        check("C_pop_s_wready", s_wready, 4'b0010);
        check("C_pop_cycle_block", s_awready, 4'b0000);
        tick;
        axi_wready = 1'b0;
        settle;
        check("C_grant_after_pop", s_awready, 4'b0010);
        tick;
        s_awvalid = '0;
        settle;
        check("C_awid_after_pop", axi_awid, 8'd1);
        s_wvalid = '0; s_wlast = '0;

        // B routing and sticky error flags
        axi_bvalid = 1'b1; axi_bid = 8'd1; axi_bresp = 2'b00; s_bready = 4'b0010;
        settle;
        check("D_s_bvalid1", s_bvalid, 4'b0010);
        check("D_bready1", axi_bready, 1'b1);
        tick;
        axi_bid = 8'd3; axi_bresp = 2'b10; s_bready = 4'b0111;
        settle;
        check("D_bready3_low", axi_bready, 1'b0);
        check("D_s_bvalid3", s_bvalid, 4'b1000);
        s_bready = 4'b1000;
        settle;
        check("D_bready3", axi_bready, 1'b1);
        tick;
        axi_bvalid = 1'b0;
        settle;
        check("D_wr_err_set", wr_err, 4'b1000);
        wr_err_clr = 4'b1000;
        tick;
        wr_err_clr = '0;
        settle;
        check("D_wr_err_clr", wr_err, 4'b0000);
        axi_bvalid = 1'b1; axi_bid = 8'd3; axi_bresp = 2'b10; s_bready = 4'b1000;
        wr_err_clr = 4'b1000;
        tick;
        axi_bvalid = 1'b0; wr_err_clr = '0;
        settle;
        check("D_set_wins", wr_err, 4'b1000);
        axi_bvalid = 1'b1; axi_bid = 8'd7; axi_bresp = 2'b10; s_bready = 4'b0000;
        settle;
        check("D_bad_id_bready", axi_bready, 1'b1);
        check("D_bad_id_s_bvalid", s_bvalid, 4'b0000);
        tick;
        axi_bvalid = 1'b0;
        settle;
        check("D_bad_id_wr_err", wr_err, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
